async_fifo: RTL and testbench

- Dual-clock FIFO with independent write clock (wclk) and read clock (rclk) domains, used for clock-domain crossing of a DW-bit data stream.
- Storage is a DEPTH-entry register array.
- Pointers cross domains as Gray codes through 2-flop synchronizers, producing full in the write domain and empty in the read domain.
- Read data is first-word fall-through: the head entry appears on rd_data without a read request.

---
 rtl/async_fifo_pkg.sv | 7 +
 rtl/sync_2ff.sv | 29 ++
 rtl/async_fifo.sv | 90 +++++++++
 tb/tb_async_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants for the dual-clock FIFO slice.
package async_fifo_pkg;

    // Flop count in each clock-domain-crossing synchronizer chain.
    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer used to move Gray-coded pointers across clock domains.
module sync_2ff
    import async_fifo_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_stage [SYNC_STAGES];

    // Shift the incoming value through the synchronizer chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stage <= '{default: '0};
        end else begin
            r_stage[0] <= d;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo.sv
// Dual-clock first-word-fall-through FIFO with Gray-coded pointer crossing.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          wclk,
    input  logic          wrstn,
    input  logic          rclk,
    input  logic          rrstn,
    input  logic          wren,
    input  logic [DW-1:0] wr_data,
    input  logic          rden,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    // Inverting the two top bits of the read pointer's Gray code marks a full ring.
    localparam logic [AW:0] FULL_MASK = (AW+1)'(3) << (AW-1);

    logic [DW-1:0] r_mem [DEPTH];

    logic [AW:0] r_wbin, r_wgray, w_wbin_next, w_wgray_next, w_wq2_rgray;
    logic [AW:0] r_rbin, r_rgray, w_rbin_next, w_rgray_next, w_rq2_wgray;
    logic        r_full, r_empty;
    logic        w_wr_go, w_rd_go;

    assign w_wr_go      = wren & ~r_full;
    assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_wr_go};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

    assign w_rd_go      = rden & ~r_empty;
    assign w_rbin_next  = r_rbin + {{AW{1'b0}}, w_rd_go};
    assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);

    // Store accepted write data; storage is intentionally not reset.
    always_ff @(posedge wclk) begin
        if (w_wr_go) begin
            r_mem[r_wbin[AW-1:0]] <= wr_data;
        end
    end

    // Write pointer and registered full flag.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_full  <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_full  <= (w_wgray_next == (w_wq2_rgray ^ FULL_MASK));
        end
    end

    // Read pointer and registered empty flag.
    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            r_rbin  <= '0;
            r_rgray <= '0;
            r_empty <= 1'b1;
        end else begin
            r_rbin  <= w_rbin_next;
            r_rgray <= w_rgray_next;
            r_empty <= (w_rgray_next == w_rq2_wgray);
        end
    end

    sync_2ff #(.W(AW+1)) u_sync_w2r (
        .clk  (rclk),
        .rstn (rrstn),
        .d    (r_wgray),
        .q    (w_rq2_wgray)
    );

    sync_2ff #(.W(AW+1)) u_sync_r2w (
        .clk  (wclk),
        .rstn (wrstn),
        .d    (r_rgray),
        .q    (w_wq2_rgray)
    );

    assign rd_data = r_mem[r_rbin[AW-1:0]];
    assign full    = r_full;
    assign empty   = r_empty;

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo (DEPTH=8, DW=8, wclk 8 ns, rclk 12 ns).
module tb_async_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic          wclk, rclk, wrstn, rrstn;
    logic          wren, rden;
    logic [DW-1:0] wr_data, rd_data;
    logic          full, empty;

    logic [DW-1:0] sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    async_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .wclk    (wclk),
        .wrstn   (wrstn),
        .rclk    (rclk),
        .rrstn   (rrstn),
        .wren    (wren),
        .wr_data (wr_data),
        .rden    (rden),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty)
    );

    // Clocks offset so that write and read edges never coincide.
    initial begin
        wclk = 1'b0;
        forever #4 wclk = ~wclk;
    end

    initial begin
        rclk = 1'b0;
        #3;
        forever #6 rclk = ~rclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One write attempt; the word is pushed only if the FIFO was not full at the edge.
    task automatic wr(input logic [DW-1:0] d, output logic acc);
        @(negedge wclk);
        acc = !full;
        if (!full) check("full_safe", 32'(sb.size() < DEPTH), 32'd1);
        wren    = 1'b1;
        wr_data = d;
        @(posedge wclk);
        if (acc) sb.push_back(d);
        #1 wren = 1'b0;
    endtask

    // One read attempt; the head word is compared before the consuming edge.
    task automatic rd(output logic acc);
        logic [DW-1:0] exp;
        @(negedge rclk);
        acc = !empty;
        if (!empty) begin
            check("empty_safe", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("rd_data", 32'(rd_data), 32'(exp));
            end
        end
        rden = 1'b1;
        @(posedge rclk);
        #1 rden = 1'b0;
    endtask

    initial begin
        logic          acc;
        logic [DW-1:0] fill_vals [10];
        int            n;

        fill_vals = '{8'hAA, 8'hB4, 8'hBE, 8'hC8, 8'hD2, 8'hDC, 8'hE6, 8'hF0, 8'hFA, 8'h04};
        wren    = 1'b0;
        rden    = 1'b1;
        wr_data = '0;
        wrstn   = 1'b0;
        rrstn   = 1'b0;

        // Reset, with a read request held to show it is not accepted.
        #15;
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        #5;
        wrstn = 1'b1;
        rrstn = 1'b1;
        repeat (3) @(posedge rclk);
        #1;
        check("rst_rden_ignored", 32'(empty), 32'd1);
        rden = 1'b0;

        // Fill past capacity with no reads.
        for (int i = 0; i < 10; i++) begin
            wr(fill_vals[i], acc);
            check($sformatf("fill_acc%0d", i), 32'(acc), 32'(i < DEPTH));
            if (i == DEPTH - 1) check("full_after_8th", 32'(full), 32'd1);
        end
        check("fill_count", 32'(sb.size()), 32'd8);
        check("full_held", 32'(full), 32'd1);

        // First read, then full must clear within three write edges.
        rd(acc);
        check("drain_acc0", 32'(acc), 32'd1);
        n = 0;
        while (full && n < 4) begin
            @(posedge wclk);
            #1 n++;
        end
        check("full_deassert", 32'(full), 32'd0);
        check("full_lat_le3", 32'(n <= 3), 32'd1);

        // Remaining reads drain in order; empty on the last one.
        for (int i = 1; i < DEPTH; i++) begin
            rd(acc);
            check($sformatf("drain_acc%0d", i), 32'(acc), 32'd1);
        end
        check("empty_after_drain", 32'(empty), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // Read while empty is ignored.
        rd(acc);
        check("rd_ignored", 32'(acc), 32'd0);
        check("empty_still", 32'(empty), 32'd1);

        // Latency: a single write into an empty FIFO.
        wr(8'h5A, acc);
        check("lat_wr_acc", 32'(acc), 32'd1);
        n = 0;
        while (empty && n < 4) begin
            @(posedge rclk);
            #1 n++;
        end
        check("lat_empty_clear", 32'(empty), 32'd0);
        check("lat_le3", 32'(n <= 3), 32'd1);
        check("lat_rd_data", 32'(rd_data), 32'h5A);
        rd(acc);
        check("lat_rd_acc", 32'(acc), 32'd1);
        check("lat_empty_again", 32'(empty), 32'd1);

        // Random concurrent traffic crossing the pointer wrap.
        fork
            begin
                logic a;
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) != 0) wr(DW'($urandom), a);
                    else @(negedge wclk);
                end
            end
            begin
                logic a;
                for (int i = 0; i < 30; i++) begin
                    if ($urandom_range(0, 2) != 0) rd(a);
                    else @(negedge rclk);
                end
            end
        join

        // Drain what remains.
        n = 0;
        while ((sb.size() > 0 || !empty) && n < 60) begin
            rd(acc);
            n++;
        end
        check("wrap_sb_drained", 32'(sb.size()), 32'd0);
        repeat (4) @(posedge rclk);
        #1;
        check("wrap_empty", 32'(empty), 32'd1);
        check("wrap_not_full", 32'(full), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
